vga_rx_monitor: RTL and testbench

//  Receiving end of the VGA output: samples hsync/vsync/vga_rgb on the 25 MHz pixel clock and rebuilds

---
 rtl/vga_rx_monitor_pkg.sv | 26 ++
 rtl/vga_rx_monitor_if.sv | 12 +
 rtl/vga_sync_edge.sv | 42 ++++
 rtl/vga_rx_monitor.sv | 229 ++++++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_rx_monitor_pkg.sv
// rtl/vga_rx_monitor_pkg.sv - shared VGA 640x480@60 timing constants, monitor state encoding and pixel type
package vga_rx_monitor_pkg;

  localparam int unsigned VGA_H_ACTIVE    = 640;
  localparam int unsigned VGA_H_FP        = 16;
  localparam int unsigned VGA_H_SYNC      = 96;
  localparam int unsigned VGA_H_BP        = 48;
  localparam int unsigned VGA_H_TOTAL     = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE    = 480;
  localparam int unsigned VGA_V_FP        = 10;
  localparam int unsigned VGA_V_SYNC      = 2;
  localparam int unsigned VGA_V_BP        = 33;
  localparam int unsigned VGA_V_TOTAL     = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned VGA_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } mon_state_e;

  typedef logic [11:0] rgb_t;

endpackage

// File: rtl/vga_rx_monitor_if.sv
// rtl/vga_rx_monitor_if.sv - VGA pin bundle between generator (master) and monitor (slave)
interface vga_rx_monitor_if;
  import vga_rx_monitor_pkg::*;

  logic hsync;
  logic vsync;
  rgb_t rgb;

  modport master (output hsync, output vsync, output rgb);
  modport slave  (input  hsync, input  vsync, input  rgb);

endinterface

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - stage-0 input registers and falling-edge pulses for hsync/vsync
module vga_sync_edge
  import vga_rx_monitor_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_hsync,
  input  logic i_vsync,
  input  rgb_t i_rgb,
  output rgb_t o_rgb,
  output logic o_hs_fall,
  output logic o_vs_fall
);

  logic r_hs;
  logic r_vs;
  logic r_hs_d;
  logic r_vs_d;
  rgb_t r_rgb;

  // Syncs idle high so a pin already low when reset releases still counts as a fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
      r_hs_d <= 1'b1;
      r_vs_d <= 1'b1;
      r_rgb  <= '0;
    end else begin
      r_hs   <= i_hsync;
      r_vs   <= i_vsync;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
      r_rgb  <= i_rgb;
    end
  end

  assign o_rgb     = r_rgb;
  assign o_hs_fall = r_hs_d & ~r_hs;
  assign o_vs_fall = r_vs_d & ~r_vs;

endmodule

// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - rebuilds pixel coordinates from VGA syncs, checks timing, tracks lock, captures one pixel
module vga_rx_monitor
  import vga_rx_monitor_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned H_FP        = VGA_H_FP,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BP        = VGA_H_BP,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned V_FP        = VGA_V_FP,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BP        = VGA_V_BP,
  parameter int unsigned LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  vga_rx_monitor_if.slave        i_vga,
  input  logic [9:0]             i_cap_x,
  input  logic [9:0]             i_cap_y,
  output logic [9:0]             o_pix_x,
  output logic [9:0]             o_pix_y,
  output rgb_t                   o_pix_data,
  output logic                   o_pix_valid,
  output logic                   o_frame_start,
  output rgb_t                   o_cap_data,
  output logic                   o_locked,
  output logic                   o_err_line,
  output logic                   o_err_frame,
  output logic [15:0]            o_frame_cnt
);

  localparam logic [10:0] L_H_LAST = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [10:0] L_H_WIN0 = 11'(H_SYNC + H_BP);
  localparam logic [10:0] L_H_WIN1 = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  L_V_LAST = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [9:0]  L_V_WIN0 = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  L_V_WIN1 = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [3:0]  L_LOCK   = 4'(LOCK_FRAMES);

  logic        w_hs_fall;
  logic        w_vs_fall;
  rgb_t        w_rgb;

  vga_sync_edge u_sync_edge (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_hsync   (i_vga.hsync),
    .i_vsync   (i_vga.vsync),
    .i_rgb     (i_vga.rgb),
    .o_rgb     (w_rgb),
    .o_hs_fall (w_hs_fall),
    .o_vs_fall (w_vs_fall)
  );

  logic [10:0] r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic        r_vs_pend;
  logic        r_lines_ok;
  logic        r_frame_start;
  logic        r_pix_valid;
  logic [9:0]  r_pix_x;
  logic [9:0]  r_pix_y;
  rgb_t        r_pix_data;
  rgb_t        r_shadow;
  mon_state_e  r_state;
  logic [3:0]  r_good;
  logic        r_locked;
  logic [15:0] r_frame_cnt;
  logic        r_err_line;
  logic        r_err_frame;
  rgb_t        r_cap_data;

  logic [10:0] w_h_now;
  logic [9:0]  w_v_now;
  logic        w_restart;
  logic        w_line_good;
  logic        w_frame_good;
  logic        w_line_bad;
  logic        w_frame_bad;
  logic        w_in_win;
  logic        w_act;
  logic [9:0]  w_pix_x;
  logic [9:0]  w_pix_y;
  logic        w_cap_hit;

  // w_h_now/w_v_now are the coordinates of the pixel currently held in the stage-0 register,
  // so the line that just ended is judged on the previous cycle's count.
  always_comb begin
    w_line_good  = (r_h_cnt == L_H_LAST);
    w_restart    = w_hs_fall && (r_vs_pend || w_vs_fall);
    w_frame_good = (r_v_cnt == L_V_LAST) && r_lines_ok && w_line_good;
    w_line_bad   = w_hs_fall && !w_line_good;
    w_frame_bad  = w_restart && !w_frame_good;

    if (w_hs_fall) begin
      w_h_now = '0;
    end else if (r_h_cnt == 11'h7FF) begin
      w_h_now = r_h_cnt;
    end else begin
      w_h_now = r_h_cnt + 11'd1;
    end

    if (w_restart) begin
      w_v_now = '0;
    end else if (w_hs_fall && (r_v_cnt != 10'h3FF)) begin
      w_v_now = r_v_cnt + 10'd1;
    end else begin
      w_v_now = r_v_cnt;
    end

    w_in_win  = (w_h_now >= L_H_WIN0) && (w_h_now <= L_H_WIN1) &&
                (w_v_now >= L_V_WIN0) && (w_v_now <= L_V_WIN1);
    w_act     = w_in_win && (r_state != ST_SEARCH);
    w_pix_x   = 10'(w_h_now - L_H_WIN0);
    w_pix_y   = w_v_now - L_V_WIN0;
    w_cap_hit = w_act && (w_pix_x == i_cap_x) && (w_pix_y == i_cap_y);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_vs_pend     <= 1'b0;
      r_lines_ok    <= 1'b0;
      r_frame_start <= 1'b0;
      r_pix_valid   <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_data    <= '0;
      r_shadow      <= '0;
    end else begin
      r_h_cnt       <= w_h_now;
      r_v_cnt       <= w_v_now;
      r_frame_start <= w_restart;
      r_pix_valid   <= w_act;

      if (w_restart) begin
        r_vs_pend <= 1'b0;
      end else if (w_vs_fall) begin
        r_vs_pend <= 1'b1;
      end

      if (w_restart) begin
        r_lines_ok <= 1'b1;
      end else if (w_line_bad) begin
        r_lines_ok <= 1'b0;
      end

      if (w_act) begin
        r_pix_x    <= w_pix_x;
        r_pix_y    <= w_pix_y;
        r_pix_data <= w_rgb;
      end

      if (w_cap_hit) begin
        r_shadow <= w_rgb;
      end
    end
  end

  // Lock FSM; cap_data only publishes the shadow once the frame it came from proves good.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_SEARCH;
      r_good      <= '0;
      r_locked    <= 1'b0;
      r_frame_cnt <= '0;
      r_err_line  <= 1'b0;
      r_err_frame <= 1'b0;
      r_cap_data  <= '0;
    end else begin
      r_err_line  <= 1'b0;
      r_err_frame <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          if (w_restart) begin
            r_state <= ST_CHECK;
            r_good  <= '0;
          end
        end
        ST_CHECK: begin
          r_err_line  <= w_line_bad;
          r_err_frame <= w_frame_bad;
          if (w_line_bad || w_frame_bad) begin
            r_good <= '0;
          end else if (w_restart) begin
            r_cap_data <= r_shadow;
            if (r_good + 4'd1 == L_LOCK) begin
              r_state     <= ST_LOCKED;
              r_locked    <= 1'b1;
              r_frame_cnt <= '0;
              r_good      <= '0;
            end else begin
              r_good <= r_good + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          r_err_line  <= w_line_bad;
          r_err_frame <= w_frame_bad;
          if (w_line_bad || w_frame_bad) begin
            r_state  <= ST_CHECK;
            r_locked <= 1'b0;
            r_good   <= '0;
          end else if (w_restart) begin
            r_cap_data  <= r_shadow;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end
        default: begin
          r_state  <= ST_SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign o_pix_x       = r_pix_x;
  assign o_pix_y       = r_pix_y;
  assign o_pix_data    = r_pix_data;
  assign o_pix_valid   = r_pix_valid;
  assign o_frame_start = r_frame_start;
  assign o_cap_data    = r_cap_data;
  assign o_locked      = r_locked;
  assign o_err_line    = r_err_line;
  assign o_err_frame   = r_err_frame;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb/tb_vga_rx_monitor.sv - directed bench for vga_rx_monitor on a scaled-down VGA raster
module tb_vga_rx_monitor;
  import vga_rx_monitor_pkg::*;

  // Scaled raster keeps the run short while preserving the sync/porch structure.
  localparam int HA = 48, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 32, VF = 2, VS = 2, VB = 4, VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  cap_x, cap_y;
  logic [9:0]  pix_x, pix_y;
  rgb_t        pix_data, cap_data;
  logic        pix_valid, frame_start, locked, err_line, err_frame;
  logic [15:0] frame_cnt;

  vga_rx_monitor_if vif ();

  vga_rx_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LOCK_FRAMES(2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_vga        (vif.slave),
    .i_cap_x      (cap_x),
    .i_cap_y      (cap_y),
    .o_pix_x      (pix_x),
    .o_pix_y      (pix_y),
    .o_pix_data   (pix_data),
    .o_pix_valid  (pix_valid),
    .o_frame_start(frame_start),
    .o_cap_data   (cap_data),
    .o_locked     (locked),
    .o_err_line   (err_line),
    .o_err_frame  (err_frame),
    .o_frame_cnt  (frame_cnt)
  );

  always #20 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   gh, gv, vtot_cur, short_line_at;
  int   drv_h, drv_v;
  int   n_el, n_ef;
  rgb_t spec_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rgb_t pix_pat(input int x, input int y);
    if (x == 10 && y == 20) return spec_val;
    return {4'(x), 4'(y), 4'hA};
  endfunction

  task automatic drive();
    int len;
    vif.hsync = (gh >= HS);
    vif.vsync = (gv >= VS);
    if (gh >= HS + HB && gh < HS + HB + HA && gv >= VS + VB && gv < VS + VB + VA)
      vif.rgb = pix_pat(gh - HS - HB, gv - VS - VB);
    else
      vif.rgb = 12'h000;
    drv_h = gh;
    drv_v = gv;
    len = (gv == short_line_at) ? HT - 1 : HT;
    if (gh >= len - 1) begin
      gh = 0;
      if (gv == short_line_at) short_line_at = -1;
      if (gv >= vtot_cur - 1) begin
        gv = 0;
        vtot_cur = VT;
      end else begin
        gv++;
      end
    end else begin
      gh++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (err_line)  n_el++;
    if (err_frame) n_ef++;
    drive();
  endtask

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    step();
    while (!frame_start && n < 3 * HT * VT) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, frame_start, 1'b1);
  endtask

  task automatic run_to(input int h, input int v, input string tag);
    int n;
    n = 0;
    while (!(drv_h == h && drv_v == v) && n < 2 * HT * VT) begin
      step();
      n++;
    end
    chk({tag, "_reach"}, (drv_h == h && drv_v == v), 1'b1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    cap_x = 10'd0;
    cap_y = 10'd0;
    gh = 0; gv = 0; vtot_cur = VT; short_line_at = -1;
    drv_h = -1; drv_v = -1;
    spec_val = 12'h3C5;
    n_el = 0; n_ef = 0;
    vif.hsync = 1'b1;
    vif.vsync = 1'b1;
    vif.rgb   = 12'h000;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked",    locked,    1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'h0);
    chk("rst_pix_valid", pix_valid, 1'b0);
    chk("rst_cap_data",  cap_data,  12'h000);
    chk("rst_err_line",  err_line,  1'b0);
    chk("rst_state",     dut.r_state, ST_SEARCH);

    // Test 1: standard timing, lock at 3rd restart
    rst_n = 1'b1;
    drive();
    wait_fs("t1_fs1");
    chk("t1_fs1_locked", locked, 1'b0);
    wait_fs("t1_fs2");
    chk("t1_fs2_locked", locked, 1'b0);
    wait_fs("t1_fs3");
    chk("t1_fs3_locked", locked, 1'b1);
    chk("t1_fs3_fcnt", frame_cnt, 16'd0);
    wait_fs("t1_fs4");
    chk("t1_fs4_fcnt", frame_cnt, 16'd1);
    chk("t1_cap_00A", cap_data, 12'h00A);
    chk("t1_no_err_line", n_el, 0);
    chk("t1_no_err_frame", n_ef, 0);

    // Test 2: pixel recovery and 2-clk latency
    run_to(HS + HB + 37, VS + VB + 5, "t2_mid");
    step(); step();
    chk("t2_mid_data", pix_data, 12'h55A);
    chk("t2_mid_x", pix_x, 10'd37);
    chk("t2_mid_y", pix_y, 10'd5);
    chk("t2_mid_valid", pix_valid, 1'b1);
    run_to(HS + HB + HA - 1, VS + VB + VA - 1, "t2_last");
    step(); step();
    chk("t2_last_data", pix_data, 12'hFFA);
    chk("t2_last_x", pix_x, 10'd47);
    chk("t2_last_y", pix_y, 10'd31);
    chk("t2_last_valid", pix_valid, 1'b1);
    step();
    chk("t2_hblank_valid", pix_valid, 1'b0);
    chk("t2_hblank_hold_x", pix_x, 10'd47);
    run_to(30, VS + VB + VA, "t2_vb");
    step(); step();
    chk("t2_vblank_valid", pix_valid, 1'b0);

    // Test 3: one short line after lock
    short_line_at = 10;
    n_el = 0; n_ef = 0;
    n = 0;
    step();
    while (!err_line && n < 2 * HT * VT) begin
      step();
      n++;
    end
    chk("t3_err_line_seen", err_line, 1'b1);
    chk("t3_locked_drop", locked, 1'b0);
    step();
    chk("t3_err_line_pulse", err_line, 1'b0);
    wait_fs("t3_r1");
    chk("t3_r1_err_frame", err_frame, 1'b1);
    chk("t3_r1_locked", locked, 1'b0);
    wait_fs("t3_r2");
    chk("t3_r2_locked", locked, 1'b0);
    wait_fs("t3_r3");
    chk("t3_r3_locked", locked, 1'b1);
    chk("t3_err_line_cnt", n_el, 1);

    // Test 4: 39-line frame after lock, capture moved mid-frame
    vtot_cur = VT - 1;
    cap_x = 10'd10;
    cap_y = 10'd20;
    n_el = 0;
    wait_fs("t4_fs");
    chk("t4_err_frame", err_frame, 1'b1);
    chk("t4_locked", locked, 1'b0);
    chk("t4_state", dut.r_state, ST_CHECK);
    chk("t4_cap_hold", cap_data, 12'h00A);
    chk("t4_no_err_line", n_el, 0);

    // Test 5: capture at (10,20), then out-of-range column
    wait_fs("t5_fs1");
    chk("t5_cap_3C5", cap_data, 12'h3C5);
    chk("t5_err_frame", err_frame, 1'b0);
    cap_x = 10'd700;
    spec_val = 12'h111;
    wait_fs("t5_fs2");
    chk("t5_cap_hold", cap_data, 12'h3C5);
    chk("t5_relocked", locked, 1'b1);

    // Test 6: asynchronous reset mid-line
    run_to(30, 15, "t6_mid");
    #5 rst_n = 1'b0;
    #1;
    chk("t6_locked", locked, 1'b0);
    chk("t6_frame_cnt", frame_cnt, 16'h0);
    chk("t6_cap_data", cap_data, 12'h000);
    chk("t6_pix_valid", pix_valid, 1'b0);
    chk("t6_pix_x", pix_x, 10'd0);
    chk("t6_pix_data", pix_data, 12'h000);
    chk("t6_state", dut.r_state, ST_SEARCH);
    repeat (3) step();
    rst_n = 1'b1;
    n_el = 0; n_ef = 0;
    wait_fs("t6_fs1");
    chk("t6_fs1_locked", locked, 1'b0);
    wait_fs("t6_fs2");
    chk("t6_fs2_locked", locked, 1'b0);
    wait_fs("t6_fs3");
    chk("t6_fs3_locked", locked, 1'b1);
    chk("t6_no_err_line", n_el, 0);
    chk("t6_no_err_frame", n_ef, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
